// File: rtl/rom_cache_pkg.sv
// Shared types, default geometry and address-split helpers for the ROM read cache.
package rom_cache_pkg;

  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_IDX_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT
  } state_e;

  // Helpers work on a 32-bit container so they serve any geometry; callers cast down.
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int idx_bits);
    return addr & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int idx_bits);
    return addr >> idx_bits;
  endfunction

endpackage

// File: rtl/rom_read_cache_if.sv
// Toggle-handshake read port: a request is pending while req != ack.
interface rom_read_cache_if #(
  parameter int AW = 20,
  parameter int DW = 64
);
  logic [AW-1:0] addr;
  logic          req;
  logic          ack;
  logic [DW-1:0] data;

  modport master (output addr, output req, input ack, input data);
  modport slave  (input addr, input req, output ack, output data);
endinterface

// File: rtl/rom_cache_ram.sv
// Simple dual-port RAM with registered read, shaped to map onto a block RAM.
module rom_cache_ram #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  // NOTE: no reset on the array; a reset would stop it mapping onto block RAM,
  // and stale contents are harmless because the valid bits gate every hit.
  logic [WIDTH-1:0] mem_q [1 << ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/rom_read_cache.sv
// Direct-mapped, one-word-per-line read cache between the core ROM fetch port
// and the DDR3 bridge read port; both sides use toggle handshakes.
module rom_read_cache
  import rom_cache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int IDX_BITS = DEF_IDX_BITS
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 flush,
  output logic                 busy,
  rom_read_cache_if.slave      cpu,
  rom_read_cache_if.master     mem
);

  localparam int TAG_W = ADDR_W - IDX_BITS;
  localparam int LINES = 1 << IDX_BITS;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                mem_req_q, mem_req_d;
  logic                flush_seen_q, flush_seen_d;
  logic [63:0]         cpu_data_q, cpu_data_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                cpu_req_q;
  logic                mem_ack_q;
  logic [63:0]         mem_data_q;

  logic [IDX_BITS-1:0] rd_idx, a_idx;
  logic [TAG_W-1:0]    a_tag, tag_rd;
  logic [63:0]         data_rd;
  logic                accept, hit, fill;

  assign rd_idx = IDX_BITS'(idx_of(32'(cpu.addr), IDX_BITS));
  assign a_idx  = IDX_BITS'(idx_of(32'(a_q), IDX_BITS));
  assign a_tag  = TAG_W'(tag_of(32'(a_q), IDX_BITS));

  assign accept = (state_q == IDLE) && (cpu_req_q != cpu_ack_q) && !flush;
  assign hit    = valid_q[a_idx] && (tag_rd == a_tag);
  assign fill   = (state_q == MISS_WAIT) && (mem_ack_q == mem_req_q);

  rom_cache_ram #(.WIDTH(TAG_W), .ADDR_BITS(IDX_BITS)) u_tag_ram (
    .clk      (clk_sys),
    .wr_en_i  (fill),
    .wr_addr_i(a_idx),
    .wr_data_i(a_tag),
    .rd_en_i  (accept),
    .rd_addr_i(rd_idx),
    .rd_data_o(tag_rd)
  );

  rom_cache_ram #(.WIDTH(64), .ADDR_BITS(IDX_BITS)) u_data_ram (
    .clk      (clk_sys),
    .wr_en_i  (fill),
    .wr_addr_i(a_idx),
    .wr_data_i(mem_data_q),
    .rd_en_i  (accept),
    .rd_addr_i(rd_idx),
    .rd_data_o(data_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP:    state_d = hit ? IDLE : MISS_WAIT;
      MISS_WAIT: if (fill) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    a_d        = a_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    cpu_ack_d  = cpu_ack_q;
    cpu_data_d = cpu_data_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: if (accept) a_d = cpu.addr;
      LOOKUP: begin
        if (hit) begin
          cpu_data_d = data_rd;
          cpu_ack_d  = ~cpu_ack_q;
        end else begin
          mem_addr_d = a_q;
          mem_req_d  = ~mem_req_q;
        end
      end
      MISS_WAIT: begin
        if (fill) begin
          cpu_data_d = mem_data_q;
          cpu_ack_d  = ~cpu_ack_q;
          if (!flush_seen_q) valid_d[a_idx] = 1'b1;
        end
      end
      default: ;
    endcase
    // Clearing beats a same-cycle fill so a line fetched across a ROM reload never survives.
    if (flush) valid_d = '0;
    flush_seen_d = (state_q != IDLE) && (flush_seen_q || flush);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      a_q          <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_data_q   <= '0;
      valid_q      <= '0;
      flush_seen_q <= 1'b0;
      cpu_req_q    <= 1'b0;
      mem_ack_q    <= 1'b0;
    end else begin
      a_q          <= a_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_data_q   <= cpu_data_d;
      valid_q      <= valid_d;
      flush_seen_q <= flush_seen_d;
      cpu_req_q    <= cpu.req;
      mem_ack_q    <= mem.ack;
    end
  end

  // Bridge data is only valid in the cycle its ack toggles, so capture it then.
  always_ff @(posedge clk_sys) begin
    if (mem.ack != mem_ack_q) mem_data_q <= mem.data;
  end

  assign cpu.ack  = cpu_ack_q;
  assign cpu.data = cpu_data_q;
  assign mem.addr = mem_addr_q;
  assign mem.req  = mem_req_q;
  assign busy     = (state_q != IDLE);

endmodule
